// File: rtl/clk_speed_switch_ctrl.sv
// rtl/clk_speed_switch_ctrl.sv - run-time speed switch sequencer for the ser/enc/fsm clock divider
//
// Sequences a gen_speed change so that the divider never switches while its
// derived clocks are running:
//   accept -> drain datapath -> gate clocks -> hold divider in reset (apply speed)
//   -> let the divided clocks settle -> ungate -> acknowledge.
// All outputs are registered. There is no combinational path from an input to an output.
//
// Optional build macro: SPEED_SW_STATS_EN adds the sw_done_cnt and sw_abort_cnt statistics outputs.
//
// Ports:
//   local_clk     in   controller clock (undivided local clock)
//   rst           in   asynchronous, active-low reset
//   req_valid     in   speed-change request valid
//   req_ready     out  high only while idle; accept = req_valid & req_ready
//   speed_sel     in   [1:0] requested speed, 2'b11 invalid
//   dp_idle       in   datapath quiescent
//   dp_stop       out  ask datapath to stop issuing traffic
//   clk_en        out  enable for divided-clock gating cells
//   div_rst_n     out  active-low divider reset
//   gen_speed     out  [1:0] speed selector to divider
//   speed_ack     out  1-cycle pulse, request completed or no-op
//   speed_err     out  1-cycle pulse, request rejected or aborted
//   err_code      out  [1:0] 01 invalid speed, 10 drain timeout; holds last value
//   sw_done_cnt   out  [7:0] saturating count of completed switches (SPEED_SW_STATS_EN)
//   sw_abort_cnt  out  [7:0] saturating count of drain timeouts (SPEED_SW_STATS_EN)

module clk_speed_switch_ctrl #(
    parameter logic [1:0] RESET_SPEED   = 2'b00,
    parameter int         DRAIN_TIMEOUT = 64,
    parameter int         GATE_CYC      = 2,
    parameter int         RST_CYC       = 4,
    parameter int         SETTLE_CYC    = 66
) (
    input  logic       local_clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] speed_sel,
    input  logic       dp_idle,
    output logic       dp_stop,
    output logic       clk_en,
    output logic       div_rst_n,
    output logic [1:0] gen_speed,
    output logic       speed_ack,
    output logic       speed_err,
    output logic [1:0] err_code
`ifdef SPEED_SW_STATS_EN
    ,
    output logic [7:0] sw_done_cnt,
    output logic [7:0] sw_abort_cnt
`endif
);

    // One down-counter is shared by every timed state. It must hold the largest reload value.
    localparam int MAX_AB = (DRAIN_TIMEOUT > GATE_CYC) ? DRAIN_TIMEOUT : GATE_CYC;
    localparam int MAX_CD = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P) + 1;

    // A state lasting N cycles is loaded with N-1. It leaves on the cycle where the count is zero.
    localparam logic [CW-1:0] LD_DRAIN  = CW'(DRAIN_TIMEOUT - 1);
    localparam logic [CW-1:0] LD_GATE   = CW'(GATE_CYC - 1);
    localparam logic [CW-1:0] LD_RESET  = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] LD_SETTLE = CW'(SETTLE_CYC - 1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_INVALID = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_GATE   = 3'd2,
        ST_RESET  = 3'd3,
        ST_SETTLE = 3'd4,
        ST_UNGATE = 3'd5
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]    target, target_d;
    logic [1:0]    gen_speed_d;
    logic [1:0]    err_code_d;
    logic          speed_ack_d, speed_err_d;
    logic          req_ready_d, dp_stop_d, clk_en_d, div_rst_n_d;
    logic          done_evt, abort_evt;
    logic          cnt_zero;

    assign cnt_zero = (cnt == '0);

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        target_d    = target;
        gen_speed_d = gen_speed;
        err_code_d  = err_code;
        speed_ack_d = 1'b0;
        speed_err_d = 1'b0;
        done_evt    = 1'b0;
        abort_evt   = 1'b0;

        case (state)
            ST_IDLE: begin
                // req_ready is high in every idle cycle, so req_valid alone means accept.
                if (req_valid) begin
                    if (speed_sel == 2'b11) begin
                        speed_err_d = 1'b1;
                        err_code_d  = ERR_INVALID;
                    end else if (speed_sel == gen_speed) begin
                        speed_ack_d = 1'b1;
                    end else begin
                        target_d = speed_sel;
                        state_d  = ST_DRAIN;
                        cnt_d    = LD_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // dp_idle is checked before the timeout. A late idle in the last cycle still switches.
                if (dp_idle) begin
                    state_d = ST_GATE;
                    cnt_d   = LD_GATE;
                end else if (cnt_zero) begin
                    state_d     = ST_IDLE;
                    speed_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    abort_evt   = 1'b1;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end

            ST_GATE: begin
                if (cnt_zero) begin
                    // The new speed is applied while the divider is entering reset.
                    state_d     = ST_RESET;
                    cnt_d       = LD_RESET;
                    gen_speed_d = target;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end

            ST_RESET: begin
                if (cnt_zero) begin
                    state_d = ST_SETTLE;
                    cnt_d   = LD_SETTLE;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end

            ST_SETTLE: begin
                if (cnt_zero) begin
                    state_d = ST_UNGATE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end

            ST_UNGATE: begin
                state_d     = ST_IDLE;
                speed_ack_d = 1'b1;
                done_evt    = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // The level outputs are decoded from the next state. Each flop then changes on the same edge as the state.
        req_ready_d = (state_d == ST_IDLE);
        dp_stop_d   = (state_d != ST_IDLE);
        clk_en_d    = !((state_d == ST_GATE) || (state_d == ST_RESET) || (state_d == ST_SETTLE));
        div_rst_n_d = (state_d != ST_RESET);
    end

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            target    <= RESET_SPEED;
            gen_speed <= RESET_SPEED;
            err_code  <= ERR_NONE;
            speed_ack <= 1'b0;
            speed_err <= 1'b0;
            req_ready <= 1'b1;
            dp_stop   <= 1'b0;
            clk_en    <= 1'b1;
            div_rst_n <= 1'b1;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            target    <= target_d;
            gen_speed <= gen_speed_d;
            err_code  <= err_code_d;
            speed_ack <= speed_ack_d;
            speed_err <= speed_err_d;
            req_ready <= req_ready_d;
            dp_stop   <= dp_stop_d;
            clk_en    <= clk_en_d;
            div_rst_n <= div_rst_n_d;
        end
    end

`ifdef SPEED_SW_STATS_EN
    // The counters count real switches and timeouts only. No-op acks and invalid-speed errors are not counted.
    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            sw_done_cnt  <= 8'h00;
            sw_abort_cnt <= 8'h00;
        end else begin
            if (done_evt && (sw_done_cnt != 8'hFF)) begin
                sw_done_cnt <= sw_done_cnt + 8'h01;
            end
            if (abort_evt && (sw_abort_cnt != 8'hFF)) begin
                sw_abort_cnt <= sw_abort_cnt + 8'h01;
            end
        end
    end
`else
    // In the default build the events still exist but nothing reads them.
    logic unused_evt;
    assign unused_evt = done_evt ^ abort_evt;
`endif

endmodule
